// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational 8-bit ALU between two requesters.
// It registers the granted operands toward the ALU and waits a settle window.
// It then captures the result and carry and returns them over a valid/ready response.
// A divide by zero is rejected without touching the ALU.
module alu_arbiter #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req0_b,
  input  logic [7:0]       req1_b,
  input  logic [3:0]       req0_sel,
  input  logic [3:0]       req1_sel,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Settle counter holds SETTLE-1 down to 0; at least one bit even for SETTLE == 1.
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [3:0] SelDiv = 4'b0011;

  typedef enum logic [1:0] {StIdle, StIssue, StSettle, StResp} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rr_last_q, rr_last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        alu_a_q, alu_a_d;
  logic [7:0]        alu_b_q, alu_b_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic [7:0]        result_q, result_d;
  logic              carry_q, carry_d;
  logic              err_q, err_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              pick;
  logic [7:0]        pick_a;
  logic [7:0]        pick_b;
  logic [3:0]        pick_sel;
  logic              pick_div0;

  // Arbitration: a lone request wins outright; on a tie the requester not served last wins.
  always_comb begin
    pick      = (req_valid == 2'b11) ? ~rr_last_q : req_valid[1];
    pick_a    = pick ? req1_a : req0_a;
    pick_b    = pick ? req1_b : req0_b;
    pick_sel  = pick ? req1_sel : req0_sel;
    pick_div0 = (pick_sel == SelDiv) && (pick_b == 8'h00);
  end

  // Next-state, datapath updates and the request-accept pulse.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_last_d   = rr_last_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    result_d    = result_q;
    carry_d     = carry_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    req_ready   = 2'b00;

    case (state_q)
      StIdle: begin
        // Gated by reset so no accept is signalled in a cycle whose edge resets the FSM.
        if ((|req_valid) && !reset) begin
          req_ready = {pick, ~pick};
          grant_d   = pick;
          rr_last_d = pick;
          if (pick_div0) begin
            // Rejected: the ALU operand registers keep their previous contents.
            result_d    = 8'h00;
            carry_d     = 1'b0;
            err_d       = 1'b1;
            rsp_valid_d = {pick, ~pick};
            state_d     = StResp;
          end else begin
            alu_a_d   = pick_a;
            alu_b_d   = pick_b;
            alu_sel_d = pick_sel;
            cnt_d     = CntW'(SETTLE - 1);
            state_d   = StIssue;
          end
        end
      end

      StIssue, StSettle: begin
        if (cnt_q == '0) begin
          result_d    = alu_out;
          carry_d     = alu_carry;
          err_d       = 1'b0;
          rsp_valid_d = {grant_q, ~grant_q};
          state_d     = StResp;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = StSettle;
        end
      end

      StResp: begin
        // Only the granted requester's ready completes the response.
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = 2'b00;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      cnt_q       <= '0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_sel_q   <= 4'h0;
      result_q    <= 8'h00;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_err    = err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign busy       = (state_q != StIdle);
  assign op_count   = op_count_q;

endmodule
